// File: rtl/risc_pkg.sv
// Shared definitions for the single-bus RISC datapath: ALU opcodes, IR field
// positions and CON condition codes.
package risc_pkg;

  localparam int DATA_W = 32;

  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_SHR  = 5'b00111;
  localparam logic [4:0] ALU_SHRA = 5'b01000;
  localparam logic [4:0] ALU_SHL  = 5'b01001;
  localparam logic [4:0] ALU_ROR  = 5'b01010;
  localparam logic [4:0] ALU_ROL  = 5'b01011;
  localparam logic [4:0] ALU_MUL  = 5'b01110;
  localparam logic [4:0] ALU_DIV  = 5'b01111;
  localparam logic [4:0] ALU_NEG  = 5'b10000;
  localparam logic [4:0] ALU_NOT  = 5'b10001;

  localparam int IR_RA_LSB  = 23;
  localparam int IR_RB_LSB  = 19;
  localparam int IR_RC_LSB  = 15;
  localparam int IR_C_MSB   = 18;
  localparam int IR_CON_LSB = 19;

  typedef enum logic [1:0] {
    CON_ZERO    = 2'b00,
    CON_NONZERO = 2'b01,
    CON_POS     = 2'b10,
    CON_NEG     = 2'b11
  } con_cond_e;

  function automatic logic [DATA_W-1:0] sext_c(input logic [IR_C_MSB:0] c);
    return {{(DATA_W-IR_C_MSB-1){c[IR_C_MSB]}}, c};
  endfunction

endpackage

// File: rtl/risc_alu.sv
// Combinational 64-bit-result ALU. Multiply/divide exist only when MULDIV_EN
// is defined; otherwise those opcodes return 0 like any unused code.
module risc_alu
  import risc_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  op,
  output logic [63:0] result
);

`ifdef MULDIV_EN
  logic signed [63:0] a_ext, b_ext, product;
  logic signed [31:0] sa, sb;
  assign a_ext   = {{32{a[31]}}, a};
  assign b_ext   = {{32{b[31]}}, b};
  assign product = a_ext * b_ext;
  assign sa      = a;
  assign sb      = b;
`endif

  logic [5:0] rot_back;
  assign rot_back = 6'd32 - {1'b0, b[4:0]};

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = {32'h0, a + b};
      ALU_SUB:  result = {32'h0, a - b};
      ALU_AND:  result = {32'h0, a & b};
      ALU_OR:   result = {32'h0, a | b};
      ALU_SHR:  result = {32'h0, a >> b[4:0]};
      ALU_SHRA: result = {32'h0, $signed(a) >>> b[4:0]};
      ALU_SHL:  result = {32'h0, a << b[4:0]};
      // a zero rotate shifts the opposite half by 32, which yields 0
      ALU_ROR:  result = {32'h0, (a >> b[4:0]) | (a << rot_back)};
      ALU_ROL:  result = {32'h0, (a << b[4:0]) | (a >> rot_back)};
`ifdef MULDIV_EN
      ALU_MUL:  result = product;
      ALU_DIV:  result = (b == 32'h0) ? 64'h0 : {sa % sb, sa / sb};
`endif
      ALU_NEG:  result = {32'h0, 32'h0 - b};
      ALU_NOT:  result = {32'h0, ~b};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/risc_datapath.sv
// Single-bus datapath of the multi-cycle RISC CPU; every strobe comes from outside.
// Optional macro MULDIV_EN enables the ALU multiply/divide opcodes.
module risc_datapath
  import risc_pkg::*;
#(
  parameter int MEM_WORDS = 512
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        PCout,
  input  logic        ZLOout,
  input  logic        ZHIout,
  input  logic        MDRout,
  input  logic        Cout,
  input  logic        BAout,
  input  logic        Rout,
  input  logic        PortInout,
  input  logic        PCin,
  input  logic        IRin,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        Yin,
  input  logic        Rin,
  input  logic        R15in,
  input  logic        ZLOin,
  input  logic        OutPortenable,
  input  logic        conin,
  input  logic        IncPC,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        read,
  input  logic        write,
  input  logic        RAMenable,
  input  logic        ZMuxEnable,
  input  logic        ZMuxOut,
  input  logic        ZSelect,
  input  logic [4:0]  aluControl,
  output logic [31:0] out
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q, out_q;
  logic [63:0] z_q;
  logic        con_q;
  logic [31:0] bus, ram_rd;
  logic [63:0] alu_res;
  logic [3:0]  sel;
  logic        con_d;
  logic [31:0] r_vec [16];
  logic [31:0] mem [MEM_WORDS];
  logic [AW-1:0] addr;

  assign addr   = mar_q[AW-1:0];
  assign ram_rd = mem[addr];
  assign out    = out_q;

  always_comb begin
    sel = 4'h0;
    if (Gra)      sel = ir_q[IR_RA_LSB +: 4];
    else if (Grb) sel = ir_q[IR_RB_LSB +: 4];
    else if (Grc) sel = ir_q[IR_RC_LSB +: 4];
  end

  // fixed-priority bus source; undriven bus reads as zero
  always_comb begin
    bus = 32'h0;
    if (PCout)                        bus = pc_q;
    else if (MDRout)                  bus = mdr_q;
    else if (ZMuxEnable && ZMuxOut)   bus = ZSelect ? z_q[63:32] : z_q[31:0];
    else if (ZHIout)                  bus = hi_q;
    else if (ZLOout)                  bus = lo_q;
    else if (Cout)                    bus = sext_c(ir_q[IR_C_MSB:0]);
    else if (PortInout)               bus = out_q;
    else if (Rout)                    bus = r_vec[sel];
    else if (BAout)                   bus = (sel == 4'h0) ? 32'h0 : r_vec[sel];
  end

  always_comb begin
    con_d = 1'b0;
    case (con_cond_e'(ir_q[IR_CON_LSB +: 2]))
      CON_ZERO:    con_d = (bus == 32'h0);
      CON_NONZERO: con_d = (bus != 32'h0);
      CON_POS:     con_d = ~bus[31];
      CON_NEG:     con_d = bus[31];
      default:     con_d = 1'b0;
    endcase
  end

  risc_alu u_alu (
    .a      (y_q),
    .b      (bus),
    .op     (aluControl),
    .result (alu_res)
  );

  for (genvar gi = 0; gi < 16; gi++) begin : g_reg
    logic [31:0] q;
    always_ff @(posedge clock or posedge clear) begin
      if (clear)                         q <= '0;
      else if (gi == 15 && R15in)        q <= bus;
      else if (Rin && sel == 4'(gi))     q <= bus;
    end
    assign r_vec[gi] = q;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      con_q <= 1'b0;
      out_q <= '0;
    end else begin
      if (PCin)       pc_q <= bus;
      else if (IncPC) pc_q <= pc_q + 32'd1;
      if (IRin)  ir_q  <= bus;
      if (MARin) mar_q <= bus;
      // RAM read sees the pre-edge word, so a simultaneous write returns old data
      if (MDRin) begin
        if (read && RAMenable) mdr_q <= ram_rd;
        else if (!read)        mdr_q <= bus;
      end
      if (Yin) y_q <= bus;
      z_q <= alu_res;
      if (ZLOin) begin
        hi_q <= z_q[63:32];
        lo_q <= z_q[31:0];
      end
      if (conin)         con_q <= con_d;
      if (OutPortenable) out_q <= bus;
    end
  end

  always_ff @(posedge clock) begin
    if (write && RAMenable) mem[addr] <= mdr_q;
  end

endmodule

// File: tb/tb_risc_datapath.sv
// Directed bench for risc_datapath with an abstract reference model checked every cycle.
module tb_risc_datapath;

  logic clock = 1'b0;
  logic clear = 1'b0;
  logic PCout, ZLOout, ZHIout, MDRout, Cout, BAout, Rout, PortInout;
  logic PCin, IRin, MARin, MDRin, Yin, Rin, R15in, ZLOin, OutPortenable, conin;
  logic IncPC, Gra, Grb, Grc, read, write, RAMenable, ZMuxEnable, ZMuxOut, ZSelect;
  logic [4:0]  aluControl;
  logic [31:0] out_w;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clock = ~clock;

  risc_datapath dut (
    .clock(clock), .clear(clear),
    .PCout(PCout), .ZLOout(ZLOout), .ZHIout(ZHIout), .MDRout(MDRout), .Cout(Cout),
    .BAout(BAout), .Rout(Rout), .PortInout(PortInout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Rin(Rin),
    .R15in(R15in), .ZLOin(ZLOin), .OutPortenable(OutPortenable), .conin(conin),
    .IncPC(IncPC), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .read(read), .write(write), .RAMenable(RAMenable),
    .ZMuxEnable(ZMuxEnable), .ZMuxOut(ZMuxOut), .ZSelect(ZSelect),
    .aluControl(aluControl), .out(out_w)
  );

  // reference model state
  logic [31:0] m_r [16];
  logic [31:0] m_ram [512];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_lo, m_out;
  logic [63:0] m_z;
  logic        m_con;
  logic [31:0] mb, mword;
  logic [3:0]  msel;

  function automatic logic [3:0] m_sel();
    if (Gra) return 4'((m_ir >> 23) & 32'hF);
    if (Grb) return 4'((m_ir >> 19) & 32'hF);
    if (Grc) return 4'((m_ir >> 15) & 32'hF);
    return 4'h0;
  endfunction

  function automatic logic [31:0] m_bus();
    logic [3:0] s;
    logic [18:0] c;
    s = m_sel();
    c = m_ir[18:0];
    if (PCout) return m_pc;
    if (MDRout) return m_mdr;
    if (ZMuxEnable && ZMuxOut) return ZSelect ? m_z[63:32] : m_z[31:0];
    if (ZHIout) return m_hi;
    if (ZLOout) return m_lo;
    if (Cout) return 32'(signed'(c));
    if (PortInout) return m_out;
    if (Rout) return m_r[s];
    if (BAout) return (s == 0) ? 32'h0 : m_r[s];
    return 32'h0;
  endfunction

  function automatic logic [63:0] m_alu(logic [31:0] a, logic [31:0] b, logic [4:0] op);
    int unsigned s;
    logic [63:0] aa, t;
    int q, r;
    longint p;
    s  = int'(b[4:0]);
    aa = {a, a};
    case (op)
      5'd3:  return {32'h0, a + b};
      5'd4:  return {32'h0, a - b};
      5'd5:  return {32'h0, a & b};
      5'd6:  return {32'h0, a | b};
      5'd7:  return {32'h0, a >> s};
      5'd8:  return {32'h0, 32'($signed(a) >>> s)};
      5'd9:  return {32'h0, a << s};
      5'd10: begin t = aa >> s; return {32'h0, t[31:0]}; end
      5'd11: begin t = aa << s; return {32'h0, t[63:32]}; end
`ifdef MULDIV_EN
      5'd14: begin p = longint'(int'(a)) * longint'(int'(b)); return 64'(p); end
      5'd15: begin
        if (b == 0) return 64'h0;
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        return {32'(r), 32'(q)};
      end
`endif
      5'd16: return {32'h0, -b};
      5'd17: return {32'h0, ~b};
      default: return 64'h0;
    endcase
  endfunction

  always @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
      m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_y = 0;
      m_z = 0; m_hi = 0; m_lo = 0; m_con = 0; m_out = 0;
    end else begin
      mb    = m_bus();
      msel  = m_sel();
      mword = m_ram[m_mar[8:0]];
      if (write && RAMenable) m_ram[m_mar[8:0]] = m_mdr;
      if (MDRin) begin
        if (read && RAMenable) m_mdr = mword;
        else if (!read) m_mdr = mb;
      end
      if (Rin) m_r[msel] = mb;
      if (R15in) m_r[15] = mb;
      if (ZLOin) begin m_hi = m_z[63:32]; m_lo = m_z[31:0]; end
      m_z = m_alu(m_y, mb, aluControl);
      if (Yin) m_y = mb;
      if (conin) begin
        case (m_ir[20:19])
          2'b00: m_con = (mb == 0);
          2'b01: m_con = (mb != 0);
          2'b10: m_con = !mb[31];
          default: m_con = mb[31];
        endcase
      end
      if (PCin) m_pc = mb;
      else if (IncPC) m_pc = m_pc + 1;
      if (IRin) m_ir = mb;
      if (MARin) m_mar = mb;
      if (OutPortenable) m_out = mb;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("out", 64'(out_w), 64'(m_out));
      chk("pc", 64'(dut.pc_q), 64'(m_pc));
      chk("ir", 64'(dut.ir_q), 64'(m_ir));
      chk("mar", 64'(dut.mar_q), 64'(m_mar));
      chk("mdr", 64'(dut.mdr_q), 64'(m_mdr));
      chk("y", 64'(dut.y_q), 64'(m_y));
      chk("z", dut.z_q, m_z);
      chk("hi", 64'(dut.hi_q), 64'(m_hi));
      chk("lo", 64'(dut.lo_q), 64'(m_lo));
      chk("con", 64'(dut.con_q), 64'(m_con));
      chk("ram_at_mar", 64'(dut.mem[m_mar[8:0]]), 64'(m_ram[m_mar[8:0]]));
      for (int i = 0; i < 16; i++) chk($sformatf("r%0d", i), 64'(dut.r_vec[i]), 64'(m_r[i]));
    end
  end

  task automatic idle();
    {PCout, ZLOout, ZHIout, MDRout, Cout, BAout, Rout, PortInout} = '0;
    {PCin, IRin, MARin, MDRin, Yin, Rin, R15in, ZLOin, OutPortenable, conin} = '0;
    {IncPC, Gra, Grb, Grc, read, write, RAMenable, ZMuxEnable, ZMuxOut, ZSelect} = '0;
    aluControl = 5'd0;
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
    idle();
  endtask

  task automatic fetch();
    PCout = 1; MARin = 1; IncPC = 1; tick();
    MDRin = 1; read = 1; RAMenable = 1; tick();
  endtask

  task automatic preload(input int a, input logic [31:0] v);
    dut.mem[a] = v;
    m_ram[a]   = v;
  endtask

  initial begin
    idle();
    for (int i = 0; i < 512; i++) preload(i, 32'h0);
    preload(0,  32'h00800055);
    preload(1,  32'h00001234);
    preload(2,  32'h00000007);
    preload(3,  32'hFFFFFFFD);
    preload(4,  32'h80000001);
    preload(5,  32'h00000001);
    preload(6,  32'h00010000);
    preload(7,  32'h00180000);
    preload(8,  32'h00000000);
    preload(9,  32'h00000001);
    preload(10, 32'h0000ABCD);
    preload(11, 32'h00000009);
    preload(12, 32'h00000005);
    preload(32'h55, 32'hCAFE0001);
    #1 clear = 1;
    @(posedge clock); #2;
    clear = 0;
    cmp_en = 1;
    chk("reset_pc", 64'(dut.pc_q), 64'h0);
    chk("reset_out", 64'(out_w), 64'h0);

    // instruction fetch and load of R1 from memory
    fetch();
    MDRout = 1; IRin = 1; tick();
    Grb = 1; BAout = 1; Yin = 1; tick();
    Cout = 1; aluControl = 5'b00011; tick();
    ZMuxEnable = 1; ZMuxOut = 1; MARin = 1; tick();
    MDRin = 1; read = 1; RAMenable = 1; tick();
    MDRout = 1; Gra = 1; Rin = 1; tick();
    chk("t2_pc", 64'(dut.pc_q), 64'h1);
    chk("t2_ir", 64'(dut.ir_q), 64'h00800055);
    chk("t2_mar", 64'(dut.mar_q), 64'h55);
    chk("t2_r1", 64'(dut.r_vec[1]), 64'hCAFE0001);

    // Rout vs BAout on R0
    fetch();
    MDRout = 1; Rin = 1; tick();
    Grb = 1; Rout = 1; OutPortenable = 1; tick();
    chk("t3_rout", 64'(out_w), 64'h1234);
    Grb = 1; BAout = 1; OutPortenable = 1; tick();
    chk("t3_baout", 64'(out_w), 64'h0);

    // ALU
    fetch();
    MDRout = 1; Yin = 1; tick();
    fetch();
    MDRout = 1; aluControl = 5'b00011; tick();
    chk("t4_add", dut.z_q, 64'h4);
    fetch();
    MDRout = 1; Yin = 1; tick();
    fetch();
    MDRout = 1; aluControl = 5'b01011; tick();
    chk("t4_rol", dut.z_q, 64'h3);
    for (int op = 0; op < 32; op++) begin
      MDRout = 1; aluControl = 5'(op); tick();
    end
    fetch();
    MDRout = 1; Yin = 1; tick();
    MDRout = 1; aluControl = 5'b01110; tick();
`ifdef MULDIV_EN
    chk("t4_mul", dut.z_q, 64'h1_00000000);
`else
    chk("t4_mul_off", dut.z_q, 64'h0);
`endif
    ZLOin = 1; ZMuxEnable = 1; ZMuxOut = 1; ZSelect = 1; OutPortenable = 1; tick();
`ifdef MULDIV_EN
    chk("t4_hi", 64'(dut.hi_q), 64'h1);
    chk("t4_zmux_hi", 64'(out_w), 64'h1);
`else
    chk("t4_hi_off", 64'(dut.hi_q), 64'h0);
`endif
    ZHIout = 1; Yin = 1; tick();
    ZLOout = 1; R15in = 1; tick();
    for (int op = 0; op < 32; op++) begin
      MDRout = 1; aluControl = 5'(op); tick();
    end
    for (int op = 0; op < 32; op++) begin
      aluControl = 5'(op); tick();
    end

    // CON flag
    fetch();
    MDRout = 1; IRin = 1; tick();
    aluControl = 5'b10001; tick();
    ZMuxEnable = 1; ZMuxOut = 1; conin = 1; tick();
    chk("t5_con_neg", 64'(dut.con_q), 64'h1);
    fetch();
    MDRout = 1; IRin = 1; tick();
    fetch();
    MDRout = 1; conin = 1; tick();
    chk("t5_con_zero", 64'(dut.con_q), 64'h0);

    // memory write/readback and output port
    fetch();
    MDRout = 1; Rin = 1; tick();
    fetch();
    MDRout = 1; MARin = 1; tick();
    chk("t6_mar", 64'(dut.mar_q), 64'h9);
    Rout = 1; MDRin = 1; tick();
    write = 1; RAMenable = 1; tick();
    MDRin = 1; tick();
    MDRin = 1; read = 1; RAMenable = 1; tick();
    chk("t6_readback", 64'(dut.mdr_q), 64'hABCD);
    MDRin = 1; tick();
    MDRin = 1; read = 1; write = 1; RAMenable = 1; tick();
    chk("t6_rw_old", 64'(dut.mdr_q), 64'hABCD);
    chk("t6_rw_mem", 64'(dut.mem[9]), 64'h0);
    MDRin = 1; read = 1; RAMenable = 1; tick();
    chk("t6_rw_new", 64'(dut.mdr_q), 64'h0);
    fetch();
    MDRout = 1; OutPortenable = 1; tick();
    chk("t6_out", 64'(out_w), 64'h5);
    PortInout = 1; Yin = 1; tick();

    // asynchronous clear in the middle of a cycle
    clear = 1;
    #1;
    chk("t1_pc", 64'(dut.pc_q), 64'h0);
    chk("t1_out", 64'(out_w), 64'h0);
    chk("t1_r0", 64'(dut.r_vec[0]), 64'h0);
    chk("t1_r1", 64'(dut.r_vec[1]), 64'h0);
    chk("t1_mdr", 64'(dut.mdr_q), 64'h0);
    chk("t1_y", 64'(dut.y_q), 64'h0);
    chk("t1_mem5", 64'(dut.mem[5]), 64'h1);
    @(posedge clock); #2;
    clear = 0;
    PCout = 1; MARin = 1; IncPC = 1; tick();
    chk("t1_restart_pc", 64'(dut.pc_q), 64'h1);
    chk("t1_restart_mar", 64'(dut.mar_q), 64'h0);
    tick();
    tick();
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
